// File: rtl/alarm_sched_if.sv
// alarm_sched_if: write/control/comparator bundle between the CPU side, the
// alarm_sched scheduler and the arlam comparator.
//   master : drives the i_* signals (CPU write path, ack/snooze, time, arlam match)
//   slave  : alarm_sched itself; drives o_arlm_time/o_arlm_en/o_ring/o_ring_slot/o_armed
interface alarm_sched_if #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned TW      = 32
);
  localparam int unsigned SW = $clog2(N_SLOTS);

  logic [TW-1:0]      i_clock_time;
  logic               i_wr_en;
  logic [SW-1:0]      i_wr_slot;
  logic [TW-1:0]      i_wr_time;
  logic               i_wr_arm;
  logic               i_ack;
  logic               i_snooze;
  logic               i_arlm_int;
  logic [TW-1:0]      o_arlm_time;
  logic               o_arlm_en;
  logic               o_ring;
  logic [SW-1:0]      o_ring_slot;
  logic [N_SLOTS-1:0] o_armed;

  modport master (
    output i_clock_time, i_wr_en, i_wr_slot, i_wr_time, i_wr_arm,
           i_ack, i_snooze, i_arlm_int,
    input  o_arlm_time, o_arlm_en, o_ring, o_ring_slot, o_armed
  );

  modport slave (
    input  i_clock_time, i_wr_en, i_wr_slot, i_wr_time, i_wr_arm,
           i_ack, i_snooze, i_arlm_int,
    output o_arlm_time, o_arlm_en, o_ring, o_ring_slot, o_armed
  );
endinterface

// File: rtl/alarm_sched.sv
// alarm_sched: time-shares the single arlam comparator between N_SLOTS alarms.
// Scans the armed slots for the nearest upcoming time (modulo 2^TW distance from
// the current time), loads it into arlam, waits for the match, rings the owning
// slot until ack / snooze / timeout, then rescans.
// Ports:
//   clk   : system clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : alarm_sched_if.slave (slot writes, ack/snooze, time of day, arlam
//           match in; arlam load value/strobe, ring, ring slot, armed flags out)
// Optional feature: define ALARM_SNOOZE_EN to enable snooze (re-arm the ringing
// slot at now + SNOOZE_TICKS). Without it i_snooze is ignored.
module alarm_sched #(
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned TW           = 32,
  parameter int unsigned RING_CYCLES  = 1000,
  parameter int unsigned SNOOZE_TICKS = 300
) (
  input  logic          clk,
  input  logic          i_rst,
  alarm_sched_if.slave  bus
);
  localparam int unsigned SW = $clog2(N_SLOTS);
  localparam int unsigned CW = $clog2(RING_CYCLES + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_SLOTS - 1);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LOAD,
    S_WAIT,
    S_RING
  } state_t;

  state_t             r_state;
  logic [TW-1:0]      r_time [N_SLOTS];
  logic [N_SLOTS-1:0] r_armed;
  logic [SW-1:0]      r_idx;
  logic [SW-1:0]      r_cand;
  logic [TW-1:0]      r_best_d;
  logic               r_found;
  logic               r_dirty;
  logic [CW-1:0]      r_ring_cnt;
  logic [TW-1:0]      r_arlm_time;
  logic               r_arlm_en;
  logic               r_ring;
  logic [SW-1:0]      r_ring_slot;

  logic [TW-1:0]      w_d;
  logic               w_take;
  logic               w_slot_ok;
  logic               w_wr_ok;
  logic               w_ring_stop;

  // Distance of the slot under scan; unsigned wrap makes "just passed" the farthest.
  assign w_d    = r_time[r_idx] - bus.i_clock_time;
  // Strict less-than keeps the lowest index on ties.
  assign w_take = r_armed[r_idx] && (!r_found || (w_d < r_best_d));

  // Slot indices beyond N_SLOTS-1 (non power-of-two counts) are dropped.
  if (N_SLOTS == (2 ** SW)) begin : g_slot_full
    assign w_slot_ok = 1'b1;
  end else begin : g_slot_part
    assign w_slot_ok = (32'(bus.i_wr_slot) < N_SLOTS);
  end
  assign w_wr_ok = bus.i_wr_en && w_slot_ok;

`ifdef ALARM_SNOOZE_EN
  logic [TW-1:0] w_snooze_time;
  assign w_snooze_time = bus.i_clock_time + TW'(SNOOZE_TICKS);
  assign w_ring_stop   = bus.i_ack || bus.i_snooze || (r_ring_cnt == RING_LAST);
`else
  logic w_unused_snooze;
  assign w_unused_snooze = bus.i_snooze ^ (SNOOZE_TICKS != 0);
  assign w_ring_stop     = bus.i_ack || (r_ring_cnt == RING_LAST);
`endif

  // Scheduler FSM, slot storage and registered outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < N_SLOTS; i++) r_time[i] <= '0;
      r_armed     <= '0;
      r_idx       <= '0;
      r_cand      <= '0;
      r_best_d    <= '0;
      r_found     <= 1'b0;
      r_dirty     <= 1'b0;
      r_ring_cnt  <= '0;
      r_arlm_time <= '0;
      r_arlm_en   <= 1'b0;
      r_ring      <= 1'b0;
      r_ring_slot <= '0;
    end else begin
      r_arlm_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|r_armed) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_found <= 1'b0;
            r_dirty <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_cand   <= r_idx;
            r_best_d <= w_d;
            r_found  <= 1'b1;
          end
          if (r_idx == LAST_SLOT) begin
            if (w_take || r_found) begin
              r_state     <= S_LOAD;
              r_arlm_en   <= 1'b1;
              r_arlm_time <= w_take ? r_time[r_idx] : r_time[r_cand];
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_idx <= r_idx + SW'(1);
          end
        end
        S_LOAD: r_state <= S_WAIT;
        S_WAIT: begin
          // Match wins over a same-cycle write; the write is still stored below.
          if (bus.i_arlm_int) begin
            r_state        <= S_RING;
            r_armed[r_cand] <= 1'b0;
            r_ring         <= 1'b1;
            r_ring_slot    <= r_cand;
            r_ring_cnt     <= '0;
          end else if (bus.i_wr_en || r_dirty) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
            r_found <= 1'b0;
            r_dirty <= 1'b0;
          end
        end
        S_RING: begin
          if (w_ring_stop) begin
            r_state <= S_SCAN;
            r_ring  <= 1'b0;
            r_idx   <= '0;
            r_found <= 1'b0;
            r_dirty <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            if (bus.i_snooze) begin
              r_time[r_ring_slot]  <= w_snooze_time;
              r_armed[r_ring_slot] <= 1'b1;
            end
`endif
          end else begin
            r_ring_cnt <= r_ring_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // CPU write lands last so it overrides a same-cycle disarm/snooze of that slot.
      if (w_wr_ok) begin
        r_time[bus.i_wr_slot]  <= bus.i_wr_time;
        r_armed[bus.i_wr_slot] <= bus.i_wr_arm;
      end
      // A write while scanning/loading may be missed by the scan; force a rescan from WAIT.
      if (bus.i_wr_en && ((r_state == S_SCAN) || (r_state == S_LOAD))) begin
        r_dirty <= 1'b1;
      end
    end
  end

  assign bus.o_arlm_time = r_arlm_time;
  assign bus.o_arlm_en   = r_arlm_en;
  assign bus.o_ring      = r_ring;
  assign bus.o_ring_slot = r_ring_slot;
  assign bus.o_armed     = r_armed;
endmodule

// File: tb/tb_alarm_sched.sv
module tb_alarm_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 32;
  localparam int unsigned RC = 8;
  localparam int unsigned ST = 300;
  localparam int unsigned SW = $clog2(N);

  logic clk = 1'b0;
  logic i_rst;

  alarm_sched_if #(.N_SLOTS(N), .TW(TW)) bus ();

  alarm_sched #(
    .N_SLOTS(N), .TW(TW), .RING_CYCLES(RC), .SNOOZE_TICKS(ST)
  ) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // arlam comparator model: register loaded on the strobe, level match output.
  logic [TW-1:0] arlam_reg;
  always @(posedge clk) begin
    if (i_rst) arlam_reg <= '0;
    else if (bus.o_arlm_en) arlam_reg <= bus.o_arlm_time;
  end
  assign bus.i_arlm_int = (bus.i_clock_time == arlam_reg);

  // Reference model: slot contents and last ringing slot.
  logic [TW-1:0] m_time [N];
  logic [N-1:0]  m_armed;
  int            m_ring_slot;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nearest armed alarm by wrap-around distance from now; lowest index on ties.
  function automatic bit model_nearest(output int slot, output logic [TW-1:0] t);
    logic [TW-1:0] best;
    logic [TW-1:0] d;
    bit found;
    found = 1'b0;
    best  = '0;
    slot  = 0;
    t     = '0;
    for (int i = 0; i < N; i++) begin
      if (m_armed[i]) begin
        d = m_time[i] - bus.i_clock_time;
        if (!found || d < best) begin
          found = 1'b1;
          best  = d;
          slot  = i;
          t     = m_time[i];
        end
      end
    end
    return found;
  endfunction

  task automatic do_wr(input int slot, input logic [TW-1:0] t, input bit arm);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_slot = SW'(slot);
    bus.i_wr_time = t;
    bus.i_wr_arm  = arm;
    tick();
    bus.i_wr_en   = 1'b0;
    m_time[slot]  = t;
    m_armed[slot] = arm;
  endtask

  // Poll for the load strobe; lat < 0 skips the latency check.
  task automatic expect_load(input string tag, input int lat);
    int n;
    int s;
    logic [TW-1:0] t;
    n = 0;
    while (bus.o_arlm_en !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check_eq({tag, "_seen"}, 64'(bus.o_arlm_en), 64'd1);
    void'(model_nearest(s, t));
    check_eq({tag, "_time"}, 64'(bus.o_arlm_time), 64'(t));
    if (lat >= 0) check_eq({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  // Let rescans finish, then the comparator must hold the model's nearest time.
  task automatic settle(input string tag);
    int quiet;
    int n;
    int s;
    logic [TW-1:0] t;
    quiet = 0;
    n     = 0;
    while (quiet < 2 * N + 6 && n < 400) begin
      tick();
      n++;
      quiet = (bus.o_arlm_en === 1'b1) ? 0 : quiet + 1;
    end
    if (model_nearest(s, t)) check_eq({tag, "_settled"}, 64'(arlam_reg), 64'(t));
    else check_eq({tag, "_none_armed"}, 64'(bus.o_armed), 64'(m_armed));
    check_eq({tag, "_quiet_ring"}, 64'(bus.o_ring), 64'd0);
  endtask

  // Move time to the nearest alarm; ring must rise one cycle after the match.
  task automatic expect_ring(input string tag, input bit from_load);
    int s;
    logic [TW-1:0] t;
    void'(model_nearest(s, t));
    if (from_load) tick();
    bus.i_clock_time = t;
    tick();
    m_armed[s]  = 1'b0;
    m_ring_slot = s;
    check_eq({tag, "_ring"}, 64'(bus.o_ring), 64'd1);
    check_eq({tag, "_slot"}, 64'(bus.o_ring_slot), 64'(m_ring_slot));
    check_eq({tag, "_armed"}, 64'(bus.o_armed), 64'(m_armed));
  endtask

  task automatic do_ack(input string tag);
    bus.i_ack = 1'b1;
    tick();
    bus.i_ack = 1'b0;
    check_eq({tag, "_ack_off"}, 64'(bus.o_ring), 64'd0);
    check_eq({tag, "_last_slot"}, 64'(bus.o_ring_slot), 64'(m_ring_slot));
  endtask

  task automatic do_snooze(input string tag, input bit with_ack);
    bus.i_snooze = 1'b1;
    bus.i_ack    = with_ack;
    tick();
    bus.i_snooze = 1'b0;
    bus.i_ack    = 1'b0;
`ifdef ALARM_SNOOZE_EN
    m_time[m_ring_slot]  = bus.i_clock_time + TW'(ST);
    m_armed[m_ring_slot] = 1'b1;
    check_eq({tag, "_snz_off"}, 64'(bus.o_ring), 64'd0);
`else
    check_eq({tag, "_snz_ring"}, 64'(bus.o_ring), 64'(!with_ack));
`endif
    check_eq({tag, "_snz_armed"}, 64'(bus.o_armed), 64'(m_armed));
    if (bus.o_ring === 1'b1) do_ack(tag);
  endtask

  task automatic expect_timeout(input string tag);
    int c;
    c = 0;
    while (bus.o_ring === 1'b1 && c < 4 * RC) begin
      c++;
      tick();
    end
    check_eq({tag, "_ring_len"}, 64'(c), 64'(RC));
  endtask

  // Nothing armed: no load may follow and all flags stay clear.
  task automatic check_idle(input string tag);
    int loads;
    loads = 0;
    repeat (2 * N + 2) begin
      tick();
      if (bus.o_arlm_en === 1'b1) loads++;
    end
    check_eq({tag, "_no_load"}, 64'(loads), 64'd0);
    check_eq({tag, "_armed0"}, 64'(bus.o_armed), 64'(m_armed));
    check_eq({tag, "_ring0"}, 64'(bus.o_ring), 64'd0);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int snz_left;
    int rings;
    logic [TW-1:0] t;
    logic [TW-1:0] base;
    logic [TW-1:0] off;

    n_checks         = 0;
    n_errors         = 0;
    i_rst            = 1'b1;
    bus.i_clock_time = '0;
    bus.i_wr_en      = 1'b0;
    bus.i_wr_slot    = '0;
    bus.i_wr_time    = '0;
    bus.i_wr_arm     = 1'b0;
    bus.i_ack        = 1'b0;
    bus.i_snooze     = 1'b0;
    for (int i = 0; i < N; i++) m_time[i] = '0;
    m_armed     = '0;
    m_ring_slot = 0;
    repeat (3) tick();
    i_rst = 1'b0;

    // Reset state; comparator reset value 0 matches time 0 but must be ignored.
    check_eq("rst_arlm_time", 64'(bus.o_arlm_time), 64'd0);
    check_eq("rst_arlm_en", 64'(bus.o_arlm_en), 64'd0);
    check_eq("rst_ring", 64'(bus.o_ring), 64'd0);
    check_eq("rst_ring_slot", 64'(bus.o_ring_slot), 64'd0);
    check_eq("rst_armed", 64'(bus.o_armed), 64'd0);
    check_idle("rst_idle");

    // Single alarm.
    bus.i_clock_time = 32'd90;
    do_wr(2, 32'd100, 1'b1);
    check_eq("single_armed", 64'(bus.o_armed), 64'h4);
    expect_load("single", N + 1);
    expect_ring("single", 1'b1);
    do_ack("single");
    check_idle("single");

    // Nearest selection across the wrap.
    bus.i_clock_time = 32'hFFFF_FFF0;
    do_wr(0, 32'h0000_0010, 1'b1);
    do_wr(1, 32'hFFFF_FFF8, 1'b1);
    settle("wrap");
    expect_ring("wrap_a", 1'b0);
    do_ack("wrap_a");
    expect_load("wrap_b", -1);
    expect_ring("wrap_b", 1'b1);
    do_ack("wrap_b");
    check_idle("wrap");

    // Tie at the same time: lower slot first, the other rings immediately after.
    bus.i_clock_time = 32'd40;
    do_wr(1, 32'd50, 1'b1);
    do_wr(3, 32'd50, 1'b1);
    settle("tie");
    expect_ring("tie_a", 1'b0);
    do_ack("tie_a");
    expect_load("tie_b", -1);
    expect_ring("tie_b", 1'b1);
    do_ack("tie_b");
    check_idle("tie");

    // Timeout without ack.
    bus.i_clock_time = 32'd60;
    do_wr(0, 32'd70, 1'b1);
    expect_load("tmo", N + 1);
    expect_ring("tmo", 1'b1);
    expect_timeout("tmo");
    check_idle("tmo");

    // Rewrite of the loaded slot while waiting.
    bus.i_clock_time = 32'd150;
    do_wr(0, 32'd200, 1'b1);
    expect_load("rw_a", N + 1);
    tick();
    do_wr(0, 32'd300, 1'b1);
    expect_load("rw_b", N);
    tick();
    bus.i_clock_time = 32'd200;
    repeat (3) tick();
    check_eq("rw_no_old_ring", 64'(bus.o_ring), 64'd0);
    expect_ring("rw_b", 1'b0);
    do_ack("rw_b");
    check_idle("rw");

    // Snooze (re-arm at now + ST with the feature, ignored without it).
    bus.i_clock_time = 32'd490;
    do_wr(2, 32'd500, 1'b1);
    expect_load("snz_a", -1);
    expect_ring("snz_a", 1'b1);
    do_snooze("snz_a", 1'b0);
    if (model_nearest(s, t)) begin
      expect_load("snz_b", -1);
      expect_ring("snz_b", 1'b1);
      do_ack("snz_b");
    end
    check_idle("snz");

    // Reset while ringing.
    bus.i_clock_time = 32'd900;
    do_wr(1, 32'd910, 1'b1);
    do_wr(3, 32'd990, 1'b1);
    expect_load("mrst", -1);
    expect_ring("mrst", 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < N; i++) m_time[i] = '0;
    m_armed     = '0;
    m_ring_slot = 0;
    check_eq("mrst_ring", 64'(bus.o_ring), 64'd0);
    check_eq("mrst_armed", 64'(bus.o_armed), 64'd0);
    check_eq("mrst_arlm_time", 64'(bus.o_arlm_time), 64'd0);
    check_eq("mrst_ring_slot", 64'(bus.o_ring_slot), 64'd0);
    check_idle("mrst");

    // Randomized: bursts of writes, then service every armed alarm.
    for (int it = 0; it < 20; it++) begin
      base             = $urandom();
      bus.i_clock_time = base;
      repeat ($urandom_range(1, N + 2)) begin
        off = ($urandom_range(0, 2) != 0) ? TW'($urandom_range(1, 20)) : ($urandom() | 32'd1);
        do_wr(int'($urandom_range(0, N - 1)), base + off, ($urandom_range(0, 3) != 0));
      end
      settle("rnd");
      snz_left = 3;
      rings    = 0;
      while (model_nearest(s, t) && rings < 40) begin
        expect_ring("rnd", (rings != 0));
        rings++;
        case ($urandom_range(0, 3))
          0, 1: do_ack("rnd");
          2: begin
            if (snz_left > 0) begin
              snz_left--;
              do_snooze("rnd", ($urandom_range(0, 1) == 1));
            end else begin
              do_ack("rnd");
            end
          end
          default: expect_timeout("rnd");
        endcase
        if (model_nearest(s, t)) expect_load("rnd_next", -1);
      end
      check_idle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
